// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   - operation encodings as seen on the unit's op input
//   - FSM state encoding
//   - default datapath width
//   - two's-complement helpers (negate / magnitude) used on operands and results
//   - funct-to-op mapping used by the control decoder
package muldiv_unit_pkg;

    localparam int MD_WIDTH = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // Two's-complement negation of a single-width value.
    function automatic logic [MD_WIDTH-1:0] twos_neg(input logic [MD_WIDTH-1:0] v);
        return ~v + {{(MD_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of a signed single-width value (0x80..0 maps to itself, read as unsigned).
    function automatic logic [MD_WIDTH-1:0] abs_val(input logic [MD_WIDTH-1:0] v);
        return v[MD_WIDTH-1] ? twos_neg(v) : v;
    endfunction

    // Two's-complement negation of a double-width product.
    function automatic logic [2*MD_WIDTH-1:0] twos_neg_dw(input logic [2*MD_WIDTH-1:0] v);
        return ~v + {{(2*MD_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // SPECIAL-opcode funct field to unit op code.
    function automatic logic [1:0] funct_to_op(input logic [5:0] funct);
        logic [1:0] op_v;
        case (funct)
            6'h18:   op_v = OP_MULT;
            6'h19:   op_v = OP_MULTU;
            6'h1A:   op_v = OP_DIV;
            6'h1B:   op_v = OP_DIVU;
            default: op_v = OP_MULT;
        endcase
        return op_v;
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start, op  issue request (accepted only in IDLE); op = MULT/MULTU/DIV/DIVU
//   rs_val     multiplicand / dividend
//   rt_val     multiplier / divisor
//   mthi/mtlo  write hi_wdata / lo_wdata into HI / LO (IDLE only, start has priority)
//   busy       high while the operation iterates (stall MFHI/MFLO and new issue)
//   done       one-cycle pulse, HI/LO already hold the new result
//   hi, lo     architectural HI / LO registers
// Signed operations run on magnitudes; the result signs are recorded at issue
// and applied in FIX. Multiply and divide share one 2*WIDTH shift register.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] hi_wdata,
    input  logic [WIDTH-1:0] lo_wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    md_state_e          state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;      // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [WIDTH-1:0]   b_r;        // multiplicand or divisor magnitude
    logic               is_div_r;
    logic               neg_q_r;    // product sign (mul) or quotient sign (div)
    logic               neg_r_r;    // remainder sign (div only)
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               busy_r;
    logic               done_r;

    logic               signed_op_s;
    logic [WIDTH-1:0]   a_mag_s;
    logic [WIDTH-1:0]   b_mag_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     rem_ext_s;
    logic [WIDTH+1:0]   trial_s;
    logic [2*WIDTH-1:0] acc_step_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quo_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;

    // Operand magnitudes at issue: MULT and DIV (op[0]==0) are the signed forms.
    always_comb begin
        signed_op_s = ~op[0];
        if (signed_op_s) begin
            a_mag_s = abs_val(rs_val);
            b_mag_s = abs_val(rt_val);
        end else begin
            a_mag_s = rs_val;
            b_mag_s = rt_val;
        end
    end

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        mul_sum_s = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, b_r};
        // Remainder shifted left with the next dividend bit; WIDTH+1 bits keep the carry.
        rem_ext_s = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
        trial_s   = {1'b0, rem_ext_s} - {2'b00, b_r};
        if (is_div_r) begin
            if (!trial_s[WIDTH+1]) begin
                acc_step_s = {trial_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_step_s = {rem_ext_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
            end
        end else if (acc_r[0]) begin
            acc_step_s = {mul_sum_s, acc_r[WIDTH-1:1]};
        end else begin
            acc_step_s = {1'b0, acc_r[2*WIDTH-1:1]};
        end
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        if (neg_q_r) begin
            prod_fix_s = twos_neg_dw(acc_r);
            quo_fix_s  = twos_neg(acc_r[WIDTH-1:0]);
        end else begin
            prod_fix_s = acc_r;
            quo_fix_s  = acc_r[WIDTH-1:0];
        end
        if (neg_r_r) begin
            rem_fix_s = twos_neg(acc_r[2*WIDTH-1:WIDTH]);
        end else begin
            rem_fix_s = acc_r[2*WIDTH-1:WIDTH];
        end
    end

    // Control FSM, datapath registers, HI/LO and registered status outputs.
    // busy/done follow the state one edge later so done pulses with busy already low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            b_r      <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            busy_r <= (state_r == ST_CALC) || (state_r == ST_FIX);
            done_r <= (state_r == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        is_div_r <= op[1];
                        neg_q_r  <= signed_op_s & (rs_val[WIDTH-1] ^ rt_val[WIDTH-1]);
                        neg_r_r  <= signed_op_s & rs_val[WIDTH-1];
                        b_r      <= b_mag_s;
                        cnt_r    <= CW'(WIDTH - 1);
                        if (op[1] && (rt_val == {WIDTH{1'b0}})) begin
                            // Divide by zero: fixed result, no iteration.
                            hi_r    <= rs_val;
                            lo_r    <= {WIDTH{1'b1}};
                            acc_r   <= {(2*WIDTH){1'b0}};
                            state_r <= ST_DONE;
                        end else begin
                            acc_r   <= {{WIDTH{1'b0}}, a_mag_s};
                            state_r <= ST_CALC;
                        end
                    end else begin
                        if (mthi) begin
                            hi_r <= hi_wdata;
                        end
                        if (mtlo) begin
                            lo_r <= lo_wdata;
                        end
                    end
                end
                ST_CALC: begin
                    acc_r <= acc_step_s;
                    cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (is_div_r) begin
                        hi_r <= rem_fix_s;
                        lo_r <= quo_fix_s;
                    end else begin
                        hi_r <= prod_fix_s[2*WIDTH-1:WIDTH];
                        lo_r <= prod_fix_s[WIDTH-1:0];
                    end
                    state_r <= ST_DONE;
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases with constant expectations,
// randomized operations checked against an arithmetic reference model, MT writes,
// ignored mid-operation requests and asynchronous reset during CALC.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs_val = 32'h0;
    logic [31:0] rt_val = 32'h0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] hi_wdata = 32'h0;
    logic [31:0] lo_wdata = 32'h0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int chk_cnt = 0;
    int pass_cnt = 0;

    muldiv_unit dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .rs_val   (rs_val),
        .rt_val   (rt_val),
        .mthi     (mthi),
        .mtlo     (mtlo),
        .hi_wdata (hi_wdata),
        .lo_wdata (lo_wdata),
        .busy     (busy),
        .done     (done),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Architectural result straight from integer arithmetic.
    function automatic void ref_model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] h, output logic [31:0] l);
        longint      sa;
        longint      sb;
        logic [63:0] t;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        t = 64'h0;
        r = 64'h0;
        h = 32'h0;
        l = 32'h0;
        case (o)
            2'b00: begin
                t = 64'(sa * sb);
                h = t[63:32];
                l = t[31:0];
            end
            2'b01: begin
                t = {32'h0, a} * {32'h0, b};
                h = t[63:32];
                l = t[31:0];
            end
            2'b10: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    t = 64'(sa / sb);
                    r = 64'(sa % sb);
                    l = t[31:0];
                    h = r[31:0];
                end
            end
            default: begin
                if (b == 32'h0) begin
                    h = a;
                    l = 32'hFFFF_FFFF;
                end else begin
                    l = a / b;
                    h = a % b;
                end
            end
        endcase
    endfunction

    // Issue one op (optionally with MT strobes in the same cycle), wait for done.
    // lat = edges after the accepting edge until done is seen (-1 on timeout).
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic mh, input logic ml, output int lat, output int bcnt);
        int n;
        @(negedge clk);
        op = o; rs_val = a; rt_val = b; start = 1'b1; mthi = mh; mtlo = ml;
        @(posedge clk);
        #1;
        start = 1'b0; mthi = 1'b0; mtlo = 1'b0;
        n = 0; lat = -1; bcnt = 0;
        while (lat < 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (busy) bcnt++;
            if (done) lat = n;
        end
        if (lat >= 0) begin
            @(posedge clk);
            #1;
            check("done_pulse", 64'(done), 64'd0);
        end
    endtask

    task automatic exec_check(input string tag, input logic [1:0] o, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        int lat;
        int bcnt;
        bit dz;
        dz = o[1] && (b == 32'h0);
        run_op(o, a, b, 1'b0, 1'b0, lat, bcnt);
        check({tag, "_hi"}, 64'(hi), 64'(eh));
        check({tag, "_lo"}, 64'(lo), 64'(el));
        check({tag, "_lat"}, 64'(lat), dz ? 64'd1 : 64'd34);
        check({tag, "_busy"}, 64'(bcnt), dz ? 64'd0 : 64'd33);
    endtask

    initial begin
        logic [31:0] eh;
        logic [31:0] el;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int          lat;
        int          bcnt;
        int          n;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // Directed cases
        exec_check("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        exec_check("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
        exec_check("div_neg",   2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        exec_check("divu",      2'b11, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E);
        exec_check("div_negdv", 2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        exec_check("divu_z",    2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF);
        exec_check("div_z",     2'b10, 32'hFFFF_FF00, 32'h0000_0000, 32'hFFFF_FF00, 32'hFFFF_FFFF);
        exec_check("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        // MT writes in IDLE
        @(negedge clk);
        hi_wdata = 32'h1234_5678; mthi = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        check("mthi", 64'(hi), 64'h1234_5678);
        check("mthi_lo_kept", 64'(lo), 64'h8000_0000);
        @(negedge clk);
        hi_wdata = 32'hCAFE_0001; lo_wdata = 32'hBEEF_0002; mthi = 1'b1; mtlo = 1'b1;
        @(posedge clk);
        #1;
        mthi = 1'b0; mtlo = 1'b0;
        check("mt_both_hi", 64'(hi), 64'hCAFE_0001);
        check("mt_both_lo", 64'(lo), 64'hBEEF_0002);

        // start and MT together: start wins
        hi_wdata = 32'hAAAA_5555; lo_wdata = 32'h5555_AAAA;
        run_op(2'b01, 32'd3, 32'd4, 1'b1, 1'b1, lat, bcnt);
        check("st_mt_hi", 64'(hi), 64'd0);
        check("st_mt_lo", 64'(lo), 64'd12);
        check("st_mt_lat", 64'(lat), 64'd34);

        // Second start and mtlo during CALC are ignored
        ref_model(2'b00, 32'hFFFF_1234, 32'h0007_ABCD, eh, el);
        @(negedge clk);
        op = 2'b00; rs_val = 32'hFFFF_1234; rt_val = 32'h0007_ABCD; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        op = 2'b11; rs_val = 32'h0000_0100; rt_val = 32'h0000_0003; start = 1'b1;
        lo_wdata = 32'hDEAD_BEEF; mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0; mtlo = 1'b0;
        n = 6; lat = -1;
        while (lat < 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (done) lat = n;
        end
        check("mid_hi", 64'(hi), 64'(eh));
        check("mid_lo", 64'(lo), 64'(el));
        check("mid_lat", 64'(lat), 64'd34);
        repeat (3) @(posedge clk);
        #1;
        check("mid_no_restart", 64'(busy), 64'd0);
        check("mid_lo_after", 64'(lo), 64'(el));

        // Asynchronous reset during CALC
        @(negedge clk);
        op = 2'b01; rs_val = 32'hFFFF_FFFF; rt_val = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk);
        #2;
        check("pre_rst_busy", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check("arst_hi", 64'(hi), 64'd0);
        check("arst_lo", 64'(lo), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_busy", 64'(busy), 64'd0);
        check("post_rst_done", 64'(done), 64'd0);
        exec_check("post_rst", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);

        // Randomized operations against the reference model
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: b = 32'($urandom_range(1, 15));
                2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                3: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            ref_model(o, a, b, eh, el);
            exec_check($sformatf("rnd%0d_op%0d", i, o), o, a, b, eh, el);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
